// File: rtl/datapath_single_cycle.sv
// Single-cycle MIPS-subset core: PC, instruction ROM, register file, decode, ALU,
// data RAM and the write-back/next-PC muxes. Memories are reached hierarchically.

package dpPkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
endpackage

// Program counter register.
// Latency: next PC visible one clk edge after it is presented.
// Backpressure: none, advances every cycle.
module pcReg (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcNext,
  output logic [31:0] pc
);
  always_ff @(posedge clk) begin
    if (rst) pc <= 32'd0;
    else     pc <= pcNext;
  end
endmodule

// Byte-wide big-endian instruction memory with a combinational word fetch.
// Latency: fetch is combinational; loader byte writes land at the clk edge.
// Backpressure: none.
module instrMem #(
  parameter int IMEM_BYTES = 256,
  localparam int IAW = $clog2(IMEM_BYTES)
) (
  input  logic           clk,
  input  logic           loadEn,
  input  logic [IAW-1:0] loadAddr,
  input  logic [7:0]     loadByte,
  input  logic [IAW-1:0] addr,
  output logic [31:0]    instr
);
  logic [7:0] MR [IMEM_BYTES];
  logic [IAW-1:0] a1, a2, a3;

  // Byte indices wrap within the array, so a word straddling the top wraps to 0.
  assign a1 = addr + IAW'(1);
  assign a2 = addr + IAW'(2);
  assign a3 = addr + IAW'(3);
  assign instr = {MR[addr], MR[a1], MR[a2], MR[a3]};

  // Contents are normally preloaded from outside; this port stays tied off in the core.
  always @(posedge clk) begin
    if (loadEn) MR[loadAddr] <= loadByte;
  end
endmodule

// 32x32 register file, two async reads, one write at the clk edge; $0 is hardwired zero.
// Latency: reads combinational, write visible after the edge (no bypass).
// Backpressure: none.
module regFile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [32];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : mem[ra2];

  always @(posedge clk) begin
    if (we && (wa != 5'd0)) mem[wa] <= wd;
  end
endmodule

// Word-addressed data memory, combinational read, write at the clk edge.
// Latency: read combinational, write visible after the edge.
// Backpressure: none.
module dataMem #(
  parameter int DMEM_WORDS = 256,
  localparam int DAW = $clog2(DMEM_WORDS)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [DAW-1:0] wordAddr,
  input  logic [31:0]    wd,
  output logic [31:0]    rdata
);
  logic [31:0] mem2 [DMEM_WORDS];

  assign rdata = mem2[wordAddr];

  always @(posedge clk) begin
    if (we) mem2[wordAddr] <= wd;
  end
endmodule

// Main decoder: opcode/funct to datapath selects and ALU operation.
// Latency: combinational.
// Backpressure: none.
module control
  import dpPkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       regDst,
  output logic       aluSrc,
  output logic       memToReg,
  output logic       regWrite,
  output logic       memWrite,
  output logic       branch,
  output logic       jump,
  output logic [2:0] aluCtl
);
  always_comb begin
    regDst   = 1'b0;
    aluSrc   = 1'b0;
    memToReg = 1'b0;
    regWrite = 1'b0;
    memWrite = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    aluCtl   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        regDst = 1'b1;
        // Unrecognised funct codes fall through as a NOP: no register write.
        case (funct)
          FN_ADD: begin aluCtl = ALU_ADD; regWrite = 1'b1; end
          FN_SUB: begin aluCtl = ALU_SUB; regWrite = 1'b1; end
          FN_AND: begin aluCtl = ALU_AND; regWrite = 1'b1; end
          FN_OR:  begin aluCtl = ALU_OR;  regWrite = 1'b1; end
          FN_SLT: begin aluCtl = ALU_SLT; regWrite = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        aluSrc   = 1'b1;
        regWrite = 1'b1;
      end
      OP_LW: begin
        aluSrc   = 1'b1;
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      OP_SW: begin
        aluSrc   = 1'b1;
        memWrite = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluCtl = ALU_SUB;
      end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end
endmodule

// 32-bit ALU: add/sub wrap, bitwise and/or, signed set-less-than.
// Latency: combinational.
// Backpressure: none.
module alu
  import dpPkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctl,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = 32'd0;
    case (ctl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

// Single-cycle core top: one instruction retires per clk rising edge.
// Latency: every output is combinational from the current PC and state.
// Backpressure: none; rst only suppresses the current instruction's writes.
module datapath_single_cycle #(
  parameter int IMEM_BYTES = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pruebaInstruccion,
  output logic [31:0] pruebaDatoSalida,
  output logic [31:0] direccionASaltar,
  output logic        selMux5db
);
  localparam int IAW = $clog2(IMEM_BYTES);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] pc, pcPlus4, pcNext, jumpTarget;
  logic [31:0] readData1, readData2, aluB, aluResult, memReadData, immExt;
  logic [4:0]  writeReg;
  logic        regDst, aluSrc, memToReg, regWrite, memWrite, branch, jump, aluZero;
  logic [2:0]  aluCtl;

  pcReg p1 (
    .clk    (clk),
    .rst    (rst),
    .pcNext (pcNext),
    .pc     (pc)
  );

  instrMem #(.IMEM_BYTES(IMEM_BYTES)) p3 (
    .clk      (clk),
    .loadEn   (1'b0),
    .loadAddr ('0),
    .loadByte (8'd0),
    .addr     (pc[IAW-1:0]),
    .instr    (pruebaInstruccion)
  );

  control p5 (
    .opcode   (pruebaInstruccion[31:26]),
    .funct    (pruebaInstruccion[5:0]),
    .regDst   (regDst),
    .aluSrc   (aluSrc),
    .memToReg (memToReg),
    .regWrite (regWrite),
    .memWrite (memWrite),
    .branch   (branch),
    .jump     (jump),
    .aluCtl   (aluCtl)
  );

  assign writeReg = regDst ? pruebaInstruccion[15:11] : pruebaInstruccion[20:16];

  regFile p7 (
    .clk (clk),
    .we  (regWrite & ~rst),
    .ra1 (pruebaInstruccion[25:21]),
    .ra2 (pruebaInstruccion[20:16]),
    .wa  (writeReg),
    .wd  (pruebaDatoSalida),
    .rd1 (readData1),
    .rd2 (readData2)
  );

  assign immExt = {{16{pruebaInstruccion[15]}}, pruebaInstruccion[15:0]};
  assign aluB   = aluSrc ? immExt : readData2;

  alu p10 (
    .a      (readData1),
    .b      (aluB),
    .ctl    (aluCtl),
    .result (aluResult),
    .zero   (aluZero)
  );

  // Byte offset bits are dropped and the word index wraps within the array.
  dataMem #(.DMEM_WORDS(DMEM_WORDS)) p16 (
    .clk      (clk),
    .we       (memWrite & ~rst),
    .wordAddr (aluResult[DAW+1:2]),
    .wd       (readData2),
    .rdata    (memReadData)
  );

  assign pruebaDatoSalida = memToReg ? memReadData : aluResult;

  assign pcPlus4          = pc + 32'd4;
  assign direccionASaltar = pcPlus4 + {immExt[29:0], 2'b00};
  assign selMux5db        = branch & aluZero;
  assign jumpTarget       = {pcPlus4[31:28], pruebaInstruccion[25:0], 2'b00};
  assign pcNext           = jump ? jumpTarget : (selMux5db ? direccionASaltar : pcPlus4);
endmodule

// File: tb/tb_datapath_single_cycle.sv
// Directed bench for the single-cycle core: program walk with per-step expectations,
// final architectural state, and reset write suppression.
`timescale 1ns/1ps

module tb_datapath_single_cycle;
  logic        clk;
  logic        rst;
  logic [31:0] pruebaInstruccion;
  logic [31:0] pruebaDatoSalida;
  logic [31:0] direccionASaltar;
  logic        selMux5db;

  int checks   = 0;
  int failures = 0;

  datapath_single_cycle #(.IMEM_BYTES(256), .DMEM_WORDS(256)) dut (
    .clk               (clk),
    .rst               (rst),
    .pruebaInstruccion (pruebaInstruccion),
    .pruebaDatoSalida  (pruebaDatoSalida),
    .direccionASaltar  (direccionASaltar),
    .selMux5db         (selMux5db)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] dato;
    logic        chkDato;
    logic        sel;
    logic [31:0] dir;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] word;
  } prog_t;

  vec_t  vecs [19];
  prog_t prog [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic loadWord(input logic [7:0] a, input logic [31:0] w);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    dut.p3.MR[a]  <= w[31:24];
    dut.p3.MR[b1] <= w[23:16];
    dut.p3.MR[b2] <= w[15:8];
    dut.p3.MR[b3] <= w[7:0];
  endtask

  initial begin
    prog[0]  = '{8'h00, 32'h20010005};  // addi $1,$0,5
    prog[1]  = '{8'h04, 32'h20020007};  // addi $2,$0,7
    prog[2]  = '{8'h08, 32'h00221820};  // add  $3,$1,$2
    prog[3]  = '{8'h0C, 32'h00222022};  // sub  $4,$1,$2
    prog[4]  = '{8'h10, 32'h10210003};  // beq  $1,$1,3 (taken)
    prog[5]  = '{8'h14, 32'h20070001};  // addi $7,$0,1 (skipped)
    prog[6]  = '{8'h20, 32'h0022282A};  // slt  $5,$1,$2
    prog[7]  = '{8'h24, 32'h8C060004};  // lw   $6,4($0)
    prog[8]  = '{8'h28, 32'hAC060008};  // sw   $6,8($0)
    prog[9]  = '{8'h2C, 32'h10220003};  // beq  $1,$2,3 (not taken)
    prog[10] = '{8'h30, 32'h20000009};  // addi $0,$0,9
    prog[11] = '{8'h34, 32'h2029FFFA};  // addi $9,$1,-6
    prog[12] = '{8'h38, 32'h0121582A};  // slt  $11,$9,$1
    prog[13] = '{8'h3C, 32'h8C0A0007};  // lw   $10,7($0) unaligned
    prog[14] = '{8'h40, 32'h00226024};  // and  $12,$1,$2
    prog[15] = '{8'h44, 32'h00226825};  // or   $13,$1,$2
    prog[16] = '{8'h48, 32'h0022703F};  // R-type unknown funct -> NOP
    prog[17] = '{8'h4C, 32'hFC000000};  // unknown opcode -> NOP
    prog[18] = '{8'h50, 32'h08000040};  // j 0x40 -> PC 0x100

    vecs[0]  = '{32'h20010005, 32'h00000005, 1'b1, 1'b0, 32'h00000018};
    vecs[1]  = '{32'h20020007, 32'h00000007, 1'b1, 1'b0, 32'h00000024};
    vecs[2]  = '{32'h00221820, 32'h0000000C, 1'b1, 1'b0, 32'h0000608C};
    vecs[3]  = '{32'h00222022, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h00008098};
    vecs[4]  = '{32'h10210003, 32'h00000000, 1'b1, 1'b1, 32'h00000020};
    vecs[5]  = '{32'h0022282A, 32'h00000001, 1'b1, 1'b0, 32'h0000A0CC};
    vecs[6]  = '{32'h8C060004, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000038};
    vecs[7]  = '{32'hAC060008, 32'h00000008, 1'b1, 1'b0, 32'h0000004C};
    vecs[8]  = '{32'h10220003, 32'hFFFFFFFE, 1'b1, 1'b0, 32'h0000003C};
    vecs[9]  = '{32'h20000009, 32'h00000009, 1'b1, 1'b0, 32'h00000058};
    vecs[10] = '{32'h2029FFFA, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000020};
    vecs[11] = '{32'h0121582A, 32'h00000001, 1'b1, 1'b0, 32'h000160E4};
    vecs[12] = '{32'h8C0A0007, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0000005C};
    vecs[13] = '{32'h00226024, 32'h00000005, 1'b1, 1'b0, 32'h000180D4};
    vecs[14] = '{32'h00226825, 32'h00000007, 1'b1, 1'b0, 32'h0001A0DC};
    vecs[15] = '{32'h0022703F, 32'h00000000, 1'b0, 1'b0, 32'h0001C148};
    vecs[16] = '{32'hFC000000, 32'h00000000, 1'b0, 1'b0, 32'h00000050};
    vecs[17] = '{32'h08000040, 32'h00000000, 1'b0, 1'b0, 32'h00000154};
    // Fetch at PC 0x100 wraps to byte 0 of the 256-byte ROM.
    vecs[18] = '{32'h20010005, 32'h00000005, 1'b1, 1'b0, 32'h00000118};

    rst = 1'b1;
    for (int i = 0; i < 256; i++) dut.p3.MR[i] <= 8'h00;
    for (int i = 0; i < 32; i++)  dut.p7.mem[i] <= 32'd0;
    for (int i = 0; i < 256; i++) dut.p16.mem2[i] <= 32'd0;
    for (int i = 0; i < 19; i++)  loadWord(prog[i].addr, prog[i].word);
    dut.p16.mem2[1] <= 32'hDEADBEEF;

    @(negedge clk);
    rst = 1'b0;
    chk("reset_instr", pruebaInstruccion, 32'h20010005);
    chk("reset_sel", {31'd0, selMux5db}, 32'd0);

    for (int i = 0; i < 19; i++) begin
      chk($sformatf("v%0d_instr", i), pruebaInstruccion, vecs[i].instr);
      if (vecs[i].chkDato) chk($sformatf("v%0d_dato", i), pruebaDatoSalida, vecs[i].dato);
      chk($sformatf("v%0d_sel", i), {31'd0, selMux5db}, {31'd0, vecs[i].sel});
      chk($sformatf("v%0d_dir", i), direccionASaltar, vecs[i].dir);
      @(negedge clk);
    end

    chk("reg0",  dut.p7.mem[0],  32'h00000000);
    chk("reg1",  dut.p7.mem[1],  32'h00000005);
    chk("reg2",  dut.p7.mem[2],  32'h00000007);
    chk("reg3",  dut.p7.mem[3],  32'h0000000C);
    chk("reg4",  dut.p7.mem[4],  32'hFFFFFFFE);
    chk("reg5",  dut.p7.mem[5],  32'h00000001);
    chk("reg6",  dut.p7.mem[6],  32'hDEADBEEF);
    chk("reg7",  dut.p7.mem[7],  32'h00000000);
    chk("reg9",  dut.p7.mem[9],  32'hFFFFFFFF);
    chk("reg10", dut.p7.mem[10], 32'hDEADBEEF);
    chk("reg11", dut.p7.mem[11], 32'h00000001);
    chk("reg12", dut.p7.mem[12], 32'h00000005);
    chk("reg13", dut.p7.mem[13], 32'h00000007);
    chk("reg14", dut.p7.mem[14], 32'h00000000);
    chk("mem2_1", dut.p16.mem2[1], 32'hDEADBEEF);
    chk("mem2_2", dut.p16.mem2[2], 32'hDEADBEEF);

    // PC now 0x104: addi $2,$0,7 is fetched; reset must drop its write.
    chk("pre_rst_instr", pruebaInstruccion, 32'h20020007);
    dut.p7.mem[2] <= 32'd123;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_suppress_reg2", dut.p7.mem[2], 32'd123);
    chk("rst_keep_reg3", dut.p7.mem[3], 32'h0000000C);
    chk("rst_keep_mem2", dut.p16.mem2[2], 32'hDEADBEEF);
    chk("rst_pc0_instr", pruebaInstruccion, 32'h20010005);
    @(negedge clk);
    chk("after_rst_instr", pruebaInstruccion, 32'h20020007);
    chk("after_rst_dato", pruebaDatoSalida, 32'h00000007);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
